sd_tx_fifo_serializer: RTL and testbench
========================================

Name: sd_tx_fifo_serializer

Overview:
Transmit-direction data FIFO for the SD data path. The host side pushes 32-bit words. The SD bus side pops 4-bit nibbles, one per read strobe, for driving DAT[3:0]. It sits between the bus-master/DMA write path and the SD data transmit state machine, in a single clock domain.

Parameters:
ADR_W, 3, pointer width including wrap bit; word depth DEPTH = 2**(ADR_W-1) (default 4 words)
BIG_ENDIAN, 1, 1: first nibble out is d[31:28], last is d[3:0]; 0: first is d[3:0], last is d[31:28]

Ports:
clk  input  1  single clock for both the push and pop sides
rst_n  input  1  asynchronous, active-low reset
clr  input  1  synchronous flush: empties the FIFO and zeroes the nibble index
d  input  32  word to push
wr  input  1  push strobe; accepted only when !full
full  output  1  no free word slot
q  output  4  current nibble; valid when !empty
rd  input  1  pop-one-nibble strobe; accepted only when !empty
last  output  1  q is the final nibble of the current word (nib_idx==7 and !empty)
empty  output  1  no complete word is pending
level  output  ADR_W  words stored, adr_i - adr_o (0..DEPTH); the word being drained counts until its 8th nibble is popped
ovr  output  1  sticky: wr attempted while full
unr  output  1  sticky: rd attempted while empty

Behaviour:
- Storage: DEPTH x 32 RAM, not reset. Write pointer adr_i and read pointer adr_o are ADR_W bits wide. The MSB is the wrap bit; the low bits index the RAM.
- Reset (rst_n=0, asynchronous): adr_i=0, adr_o=0, nib_idx=0, ovr=0, unr=0. Outputs then read empty=1, full=0, level=0, last=0. RAM contents are untouched. Reset mid-word discards the partially drained word.
- Push: on a clk edge with wr & !full, ram[adr_i low] <= d and adr_i increments. When the low bits reach DEPTH-1, they wrap to 0 and the MSB toggles.
- wr & full: no write and no pointer change; ovr <= 1.
- Pop: on a clk edge with rd & !empty, nib_idx increments. When nib_idx==7, nib_idx <= 0 and adr_o increments with the same wrap rule as adr_i.
- rd & empty: no change; unr <= 1.
- q is combinational from ram[adr_o low] and nib_idx:
  - BIG_ENDIAN=1: q = word[31-4*nib_idx -: 4].
  - BIG_ENDIAN=0: q = word[4*nib_idx +: 4].
  - q is don't-care while empty.
- full = (low bits of adr_i == low bits of adr_o) & (MSBs differ). empty = (adr_i == adr_o). Both are derived purely from the registered pointers.
- Simultaneous wr & rd:
  - Both are evaluated against pre-edge full/empty.
  - When full, a rd that completes a word frees the slot only at the next edge, so the concurrent wr is rejected and ovr is set.
  - When empty, the concurrent rd is rejected and unr is set, while the wr is accepted.
- Latency: a pushed word is visible (empty=0, q = first nibble) in the cycle after the push edge.
- Throughput: 1 word per cycle on push, 1 nibble per cycle on pop.
- clr=1 at a clk edge:
  - adr_o <= adr_i, nib_idx <= 0, ovr <= 0, unr <= 0.
  - clr has priority over wr and rd in that cycle; both are ignored and do not set flags.
- level is a modulo-2**ADR_W subtraction and reaches DEPTH exactly when full.

Test Plan:
1. Reset, BIG_ENDIAN=1: push 32'h12345678, then hold rd=1 for 8 cycles -> q sequence 1,2,3,4,5,6,7,8. last=1 only on the 8th nibble. Then empty=1, level=0, unr=0.
2. BIG_ENDIAN=0: push 32'h12345678 and drain -> q sequence 8,7,6,5,4,3,2,1.
3. Fill and overflow: push 4 words (A0000001..A0000004) -> full=1, level=4. A 5th push is ignored and ovr=1. Drain 32 nibbles -> the four words come out in order and empty=1.
4. Wrap: cycle 10 words through with level kept at 1-3 using interleaved wr/rd -> every nibble correct across the pointer wrap, and full/empty never false.
5. Boundary: at full, rd on the 8th nibble together with wr -> wr rejected (ovr=1), level=3 next cycle. At empty, wr and rd together -> wr accepted, unr=1, level=1.
6. Pop 3 nibbles of 32'hDEADBEEF, then clr -> empty=1, level=0, nib_idx=0. Next push of 32'hCAFEF00D drains starting at C. Asserting rst_n=0 mid-drain gives the same empty state asynchronously.

Source files
------------

// File: rtl/sd_tx_fifo_serializer.sv
// ============================================================================
// Module  : sd_tx_fifo_serializer
// Brief   : SD transmit FIFO that takes 32-bit words and hands out 4-bit nibbles
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_tx_fifo_serializer #(
  parameter int ADR_W      = 3,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [31:0]      d,
  input  logic             wr,
  output logic             full,
  output logic [3:0]       q,
  input  logic             rd,
  output logic             last,
  output logic             empty,
  output logic [ADR_W-1:0] level,
  output logic             ovr,
  output logic             unr
);

  localparam int               c_depth   = 2 ** (ADR_W - 1);
  localparam logic [ADR_W-1:0] c_adr_one = {{(ADR_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_ram [c_depth];
  logic [ADR_W-1:0] r_adr_i;
  logic [ADR_W-1:0] r_adr_o;
  logic [2:0]       r_nib_idx;
  logic             r_ovr;
  logic             r_unr;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic [31:0]      w_word;
  logic [2:0]       w_sel;

  assign w_full  = (r_adr_i[ADR_W-2:0] == r_adr_o[ADR_W-2:0]) &&
                   (r_adr_i[ADR_W-1] != r_adr_o[ADR_W-1]);
  assign w_empty = (r_adr_i == r_adr_o);
  assign w_push  = wr && !w_full && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr_i   <= '0;
      r_adr_o   <= '0;
      r_nib_idx <= 3'd0;
      r_ovr     <= 1'b0;
      r_unr     <= 1'b0;
    end else if (clr) begin
      r_adr_o   <= r_adr_i;
      r_nib_idx <= 3'd0;
      r_ovr     <= 1'b0;
      r_unr     <= 1'b0;
    end else begin
      if (wr) begin
        if (w_full) r_ovr   <= 1'b1;
        else        r_adr_i <= r_adr_i + c_adr_one;
      end
      // Full/empty are judged on pre-edge pointers, so a word finishing now
      // does not make room for a push in the same cycle.
      if (rd) begin
        if (w_empty) begin
          r_unr <= 1'b1;
        end else begin
          r_nib_idx <= r_nib_idx + 3'd1;
          if (r_nib_idx == 3'd7) r_adr_o <= r_adr_o + c_adr_one;
        end
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_ram[r_adr_i[ADR_W-2:0]] <= d;
  end

  assign w_word = r_ram[r_adr_o[ADR_W-2:0]];
  assign w_sel  = BIG_ENDIAN ? ~r_nib_idx : r_nib_idx;

  assign q     = w_word[{w_sel, 2'b00} +: 4];
  assign full  = w_full;
  assign empty = w_empty;
  assign last  = !w_empty && (r_nib_idx == 3'd7);
  assign level = r_adr_i - r_adr_o;
  assign ovr   = r_ovr;
  assign unr   = r_unr;

endmodule

`default_nettype wire

// File: tb/tb_sd_tx_fifo_serializer.sv
// ============================================================================
// Module  : tb_sd_tx_fifo_serializer
// Brief   : Directed bench with a queue-based reference model, both nibble orders
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_tx_fifo_serializer;

  localparam int ADR_W = 3;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [31:0]      d;
  logic             wr;
  logic             rd;
  logic             full_be, last_be, empty_be, ovr_be, unr_be;
  logic             full_le, last_le, empty_le, ovr_le, unr_le;
  logic [3:0]       q_be, q_le;
  logic [ADR_W-1:0] level_be, level_le;

  int n_cmp;
  int n_fail;
  bit chk_en;

  sd_tx_fifo_serializer #(.ADR_W(ADR_W), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .clr(clr), .d(d), .wr(wr), .full(full_be),
    .q(q_be), .rd(rd), .last(last_be), .empty(empty_be), .level(level_be),
    .ovr(ovr_be), .unr(unr_be)
  );

  sd_tx_fifo_serializer #(.ADR_W(ADR_W), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .clr(clr), .d(d), .wr(wr), .full(full_le),
    .q(q_le), .rd(rd), .last(last_le), .empty(empty_le), .level(level_le),
    .ovr(ovr_le), .unr(unr_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of whole words plus the nibble position in the head word.
  logic [31:0] mq[$];
  int          mnib;
  bit          movr;
  bit          munr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mnib = 0;
      movr = 0;
      munr = 0;
    end else if (clr) begin
      mq.delete();
      mnib = 0;
      movr = 0;
      munr = 0;
    end else begin
      int  sz;
      sz = mq.size();
      if (rd) begin
        if (sz == 0) munr = 1;
        else begin
          mnib = mnib + 1;
          if (mnib == 8) begin
            mnib = 0;
            void'(mq.pop_front());
          end
        end
      end
      if (wr) begin
        if (sz == DEPTH) movr = 1;
        else mq.push_back(d);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] w;
      int          sz;
      sz = mq.size();
      chk("empty_be", 32'(empty_be), 32'(sz == 0));
      chk("empty_le", 32'(empty_le), 32'(sz == 0));
      chk("full_be",  32'(full_be),  32'(sz == DEPTH));
      chk("full_le",  32'(full_le),  32'(sz == DEPTH));
      chk("level_be", 32'(level_be), 32'(sz));
      chk("level_le", 32'(level_le), 32'(sz));
      chk("ovr",      32'(ovr_be),   32'(movr));
      chk("unr",      32'(unr_le),   32'(munr));
      chk("last_be",  32'(last_be),  32'(sz != 0 && mnib == 7));
      chk("last_le",  32'(last_le),  32'(sz != 0 && mnib == 7));
      if (sz != 0) begin
        w = mq[0];
        chk("q_be", 32'(q_be), (w >> (28 - 4 * mnib)) & 32'hF);
        chk("q_le", 32'(q_le), (w >> (4 * mnib)) & 32'hF);
      end
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [31:0] dd);
    wr = w;
    rd = r;
    d  = dd;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic do_clr(input logic w, input logic r);
    clr = 1'b1;
    cyc(w, r, 32'hFFFF_FFFF);
    clr = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    logic [31:0] lit;
    logic [31:0] acc;
    n_cmp = 0; n_fail = 0; chk_en = 0;
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; d = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;

    chk("rst_empty", 32'(empty_be), 32'd1);
    chk("rst_full",  32'(full_be),  32'd0);
    chk("rst_level", 32'(level_be), 32'd0);
    chk("rst_last",  32'(last_be),  32'd0);

    // Single word, both nibble orders.
    cyc(1'b1, 1'b0, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      chk("seq_be",  32'(q_be),    32'(i + 1));
      chk("seq_le",  32'(q_le),    32'(8 - i));
      chk("seq_last", 32'(last_be), 32'(i == 7));
      cyc(1'b0, 1'b1, 32'h0);
    end
    chk("t1_empty", 32'(empty_be), 32'd1);
    chk("t1_level", 32'(level_be), 32'd0);
    chk("t1_unr",   32'(unr_be),   32'd0);

    // Fill, overflow, drain in order.
    for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b0, 32'hA000_0000 + 32'(k));
    chk("t3_full",  32'(full_be),  32'd1);
    chk("t3_level", 32'(level_be), 32'd4);
    cyc(1'b1, 1'b0, 32'hA000_0005);
    chk("t3_ovr",   32'(ovr_be),   32'd1);
    for (int k = 1; k <= 4; k++) begin
      acc = 32'h0;
      for (int i = 0; i < 8; i++) begin
        acc = {acc[27:0], q_be};
        cyc(1'b0, 1'b1, 32'h0);
      end
      lit = 32'hA000_0000 + 32'(k);
      chk("t3_word", acc, lit);
    end
    chk("t3_empty", 32'(empty_be), 32'd1);
    do_clr(1'b1, 1'b1);
    chk("clr_ovr",   32'(ovr_be),   32'd0);
    chk("clr_level", 32'(level_be), 32'd0);

    // Pointer wrap with level held between 2 and 3.
    cyc(1'b1, 1'b0, 32'h0F1E_2D3C);
    cyc(1'b1, 1'b0, 32'h0F1E_2D3C + 32'h1111_1111);
    for (int k = 2; k < 10; k++) begin
      for (int i = 0; i < 8; i++) begin
        cyc(i == 0, 1'b1, 32'h0F1E_2D3C + 32'h1111_1111 * 32'(k));
        chk("t4_nofull",  32'(full_be),  32'd0);
        chk("t4_nempty",  32'(empty_be), 32'd0);
      end
    end
    drain(16);
    chk("t4_empty", 32'(empty_be), 32'd1);

    // Boundary: full with word-completing rd plus wr.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 32'hB000_0000 + 32'(k));
    drain(7);
    chk("t5_full7", 32'(full_be), 32'd1);
    cyc(1'b1, 1'b1, 32'hBBBB_BBBB);
    chk("t5_ovr",   32'(ovr_be),   32'd1);
    chk("t5_level", 32'(level_be), 32'd3);
    drain(24);
    do_clr(1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h55AA_33CC);
    chk("t5_unr",    32'(unr_be),   32'd1);
    chk("t5_level1", 32'(level_be), 32'd1);
    chk("t5_q",      32'(q_be),     32'h5);
    drain(8);

    // Flush mid-word, then async reset mid-word.
    cyc(1'b1, 1'b0, 32'hDEAD_BEEF);
    drain(3);
    do_clr(1'b0, 1'b0);
    chk("t6_empty", 32'(empty_be), 32'd1);
    chk("t6_level", 32'(level_be), 32'd0);
    cyc(1'b1, 1'b0, 32'hCAFE_F00D);
    chk("t6_q0",   32'(q_be), 32'hC);
    chk("t6_q0le", 32'(q_le), 32'hD);
    drain(2);
    chk("t6_q2", 32'(q_be), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(empty_be), 32'd1);
    chk("t6_rst_level", 32'(level_be), 32'd0);
    chk("t6_rst_last",  32'(last_le),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 32'h9876_5432);
    chk("t6_post_q", 32'(q_be), 32'h9);
    drain(8);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
